// File: rtl/char_motion_sequencer.sv
// ---------------------------------------------------------------------------
// char_motion_sequencer
// Frame-driven motion controller for the player character. Decodes the HID
// keycode slots, runs the GROUND/CHARGE/RISE/FALL/LAND state machine and owns
// the X/Y position registers, clamping at the playfield walls, ceiling and
// floor. All state advances only on CLK edges where frame_tick is high.
//
// Ports
//   CLK          in   1   system clock
//   Reset        in   1   asynchronous active-low reset
//   frame_tick   in   1   one-CLK pulse per video frame
//   keycode0/1   in   8   HID keycode slots (0x00 = none)
//   Char_X_Pos   out  10  character centre X (registered)
//   Char_Y_Pos   out  10  character centre Y (registered)
//   charge_level out  4   current jump charge
//   airborne     out  1   high in RISE or FALL (registered)
//   HEXstate     out  4   GROUND=0 CHARGE=1 RISE=2 FALL=3 LAND=4
// ---------------------------------------------------------------------------
module char_motion_sequencer #(
   parameter int X_START     = 320,
   parameter int Y_START     = 240,
   parameter int X_MIN       = 20,
   parameter int X_MAX       = 639,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 405,
   parameter int CHAR_SIZE   = 4,
   parameter int X_STEP      = 1,
   parameter int X_AIR       = 2,
   parameter int CHARGE_MAX  = 12,
   parameter int VY_MAX      = 8,
   parameter int LAND_FRAMES = 6
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode0,
   input  logic [7:0] keycode1,
   output logic [9:0] Char_X_Pos,
   output logic [9:0] Char_Y_Pos,
   output logic [3:0] charge_level,
   output logic       airborne,
   output logic [3:0] HEXstate
);

   // State encoding doubles as the HEXstate code so that output is a pure register.
   typedef enum logic [3:0] {
      ST_GROUND = 4'd0,
      ST_CHARGE = 4'd1,
      ST_RISE   = 4'd2,
      ST_FALL   = 4'd3,
      ST_LAND   = 4'd4
   } state_t;

   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;

   // Limits in 11-bit signed so intermediate sums never wrap before clamping.
   localparam logic signed [10:0] X_LO     = 11'(X_MIN + CHAR_SIZE);
   localparam logic signed [10:0] X_HI     = 11'(X_MAX - CHAR_SIZE);
   localparam logic signed [10:0] Y_LO     = 11'(Y_MIN + CHAR_SIZE);
   localparam logic signed [10:0] Y_HI     = 11'(Y_MAX - CHAR_SIZE);
   localparam logic signed [10:0] X_STEP_S = 11'(X_STEP);
   localparam logic signed [3:0]  VX_AIR   = 4'(X_AIR);
   localparam logic [3:0]         CHG_MAX  = 4'(CHARGE_MAX);
   localparam logic [4:0]         VY_LIM   = 5'(VY_MAX);
   localparam logic [2:0]         LAND_END = 3'(LAND_FRAMES - 1);

   state_t            state_r, state_n_s;
   logic [9:0]        x_r, x_n_s;
   logic [9:0]        y_r, y_n_s;
   logic signed [3:0] vx_r, vx_n_s;
   logic [4:0]        vy_r, vy_n_s;
   logic [3:0]        charge_r, charge_n_s;
   logic [2:0]        land_cnt_r, land_cnt_n_s;
   logic              airborne_r;

   logic              space_s, a_s, d_s, left_s, right_s;
   logic signed [10:0] x_ext_s, y_ext_s, vx_ext_s, vy_ext_s;
   logic signed [10:0] xa_s, x_air_s, y_rise_s, y_fall_s, x_walk_s;
   logic signed [3:0]  vx_air_s;
   logic [4:0]         vy_dec_s, vy_inc_s;

   // Key decode: a key counts as held if it appears in either slot; A+D cancel.
   always_comb begin
      space_s = (keycode0 == KEY_SPACE) || (keycode1 == KEY_SPACE);
      a_s     = (keycode0 == KEY_A)     || (keycode1 == KEY_A);
      d_s     = (keycode0 == KEY_D)     || (keycode1 == KEY_D);
      left_s  = a_s && !d_s;
      right_s = d_s && !a_s;
   end

   // Shared arithmetic: airborne horizontal move with wall bounce, rise/fall Y.
   always_comb begin
      x_ext_s  = $signed({1'b0, x_r});
      y_ext_s  = $signed({1'b0, y_r});
      vx_ext_s = $signed({{7{vx_r[3]}}, vx_r});
      xa_s     = x_ext_s + vx_ext_s;
      if (xa_s < X_LO) begin
         x_air_s  = X_LO;
         vx_air_s = -vx_r;
      end else if (xa_s > X_HI) begin
         x_air_s  = X_HI;
         vx_air_s = -vx_r;
      end else begin
         x_air_s  = xa_s;
         vx_air_s = vx_r;
      end
      vy_dec_s = (vy_r == 5'd0) ? 5'd0 : (vy_r - 5'd1);
      vy_inc_s = (vy_r >= VY_LIM) ? VY_LIM : (vy_r + 5'd1);
      vy_ext_s = $signed({6'd0, vy_r});
      y_rise_s = y_ext_s - vy_ext_s;
      y_fall_s = y_ext_s + $signed({6'd0, vy_inc_s});
      x_walk_s = x_ext_s;
   end

   // Next-state and datapath update, evaluated only when frame_tick is high.
   always_comb begin
      state_n_s    = state_r;
      x_n_s        = x_r;
      y_n_s        = y_r;
      vx_n_s       = vx_r;
      vy_n_s       = vy_r;
      charge_n_s   = charge_r;
      land_cnt_n_s = land_cnt_r;
      if (frame_tick) begin
         case (state_r)
            ST_GROUND: begin
               if (space_s) begin
                  state_n_s  = ST_CHARGE;
                  charge_n_s = 4'd1;
               end else if (left_s) begin
                  if ((x_walk_s - X_STEP_S) < X_LO) begin
                     x_n_s = 10'(X_LO);
                  end else begin
                     x_n_s = 10'(x_walk_s - X_STEP_S);
                  end
               end else if (right_s) begin
                  if ((x_walk_s + X_STEP_S) > X_HI) begin
                     x_n_s = 10'(X_HI);
                  end else begin
                     x_n_s = 10'(x_walk_s + X_STEP_S);
                  end
               end else begin
                  x_n_s = x_r;
               end
            end
            ST_CHARGE: begin
               if (space_s) begin
                  charge_n_s = (charge_r >= CHG_MAX) ? CHG_MAX : (charge_r + 4'd1);
               end else begin
                  state_n_s  = ST_RISE;
                  vy_n_s     = {1'b0, charge_r};
                  charge_n_s = 4'd0;
                  if (left_s) begin
                     vx_n_s = -VX_AIR;
                  end else if (right_s) begin
                     vx_n_s = VX_AIR;
                  end else begin
                     vx_n_s = 4'sd0;
                  end
               end
            end
            ST_RISE: begin
               x_n_s  = 10'(x_air_s);
               vx_n_s = vx_air_s;
               // Ceiling hit ends the rise at once with zero vertical speed.
               if (y_rise_s <= Y_LO) begin
                  y_n_s     = 10'(Y_LO);
                  vy_n_s    = 5'd0;
                  state_n_s = ST_FALL;
               end else begin
                  y_n_s     = 10'(y_rise_s);
                  vy_n_s    = vy_dec_s;
                  state_n_s = (vy_dec_s == 5'd0) ? ST_FALL : ST_RISE;
               end
            end
            ST_FALL: begin
               x_n_s = 10'(x_air_s);
               if (y_fall_s >= Y_HI) begin
                  y_n_s        = 10'(Y_HI);
                  vy_n_s       = 5'd0;
                  vx_n_s       = 4'sd0;
                  land_cnt_n_s = 3'd0;
                  state_n_s    = ST_LAND;
               end else begin
                  y_n_s  = 10'(y_fall_s);
                  vy_n_s = vy_inc_s;
                  vx_n_s = vx_air_s;
               end
            end
            ST_LAND: begin
               if (land_cnt_r == LAND_END) begin
                  land_cnt_n_s = 3'd0;
                  state_n_s    = ST_GROUND;
               end else begin
                  land_cnt_n_s = land_cnt_r + 3'd1;
               end
            end
            default: begin
               state_n_s = ST_FALL;
            end
         endcase
      end else begin
         state_n_s = state_r;
      end
   end

   // State and datapath registers with asynchronous reset to the drop-in pose.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_r    <= ST_FALL;
         x_r        <= 10'(X_START);
         y_r        <= 10'(Y_START);
         vx_r       <= 4'sd0;
         vy_r       <= 5'd0;
         charge_r   <= 4'd0;
         land_cnt_r <= 3'd0;
         airborne_r <= 1'b1;
      end else begin
         state_r    <= state_n_s;
         x_r        <= x_n_s;
         y_r        <= y_n_s;
         vx_r       <= vx_n_s;
         vy_r       <= vy_n_s;
         charge_r   <= charge_n_s;
         land_cnt_r <= land_cnt_n_s;
         airborne_r <= (state_n_s == ST_RISE) || (state_n_s == ST_FALL);
      end
   end

   assign Char_X_Pos   = x_r;
   assign Char_Y_Pos   = y_r;
   assign charge_level = charge_r;
   assign airborne     = airborne_r;
   assign HEXstate     = state_r;

endmodule

// File: tb/tb_char_motion_sequencer.sv
// ---------------------------------------------------------------------------
// tb_char_motion_sequencer
// Directed bench for char_motion_sequencer. The main instance uses default
// parameters; a second instance with a low start and a shallow floor is used
// to reach the ceiling, which a default-size jump cannot do.
// ---------------------------------------------------------------------------
module tb_char_motion_sequencer;

   logic       clk_s;
   logic       rst_n_s;
   logic       tick_s, tick_c_s;
   logic [7:0] k0_s, k1_s, k0_c_s, k1_c_s;
   logic [9:0] x_s, y_s, x_c_s, y_c_s;
   logic [3:0] chg_s, chg_c_s, hex_s, hex_c_s;
   logic       air_s, air_c_s;

   int checks_cnt = 0;
   int errors_cnt = 0;
   int n_ticks;

   char_motion_sequencer dut (
      .CLK(clk_s), .Reset(rst_n_s), .frame_tick(tick_s),
      .keycode0(k0_s), .keycode1(k1_s),
      .Char_X_Pos(x_s), .Char_Y_Pos(y_s), .charge_level(chg_s),
      .airborne(air_s), .HEXstate(hex_s)
   );

   char_motion_sequencer #(.Y_START(30), .Y_MAX(60)) dut_c (
      .CLK(clk_s), .Reset(rst_n_s), .frame_tick(tick_c_s),
      .keycode0(k0_c_s), .keycode1(k1_c_s),
      .Char_X_Pos(x_c_s), .Char_Y_Pos(y_c_s), .charge_level(chg_c_s),
      .airborne(air_c_s), .HEXstate(hex_c_s)
   );

   initial clk_s = 1'b0;
   always #5 clk_s = ~clk_s;

   task automatic check(input string tag, input int got, input int exp);
      checks_cnt++;
      if (got != exp) begin
         errors_cnt++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One frame tick on the main instance; outputs sampled on the following negedge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_s);
         tick_s = 1'b1;
         @(negedge clk_s);
         tick_s = 1'b0;
      end
   endtask

   task automatic tick_c(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_s);
         tick_c_s = 1'b1;
         @(negedge clk_s);
         tick_c_s = 1'b0;
      end
   endtask

   initial begin
      rst_n_s = 1'b0; tick_s = 1'b0; tick_c_s = 1'b0;
      k0_s = 8'h00; k1_s = 8'h00; k0_c_s = 8'h00; k1_c_s = 8'h00;
      repeat (3) @(negedge clk_s);
      check("rst_x", x_s, 320);
      check("rst_y", y_s, 240);
      check("rst_hex", hex_s, 3);
      check("rst_air", air_s, 1);
      check("rst_chg", chg_s, 0);
      rst_n_s = 1'b1;

      // Drop from reset: 8 accelerating ticks to terminal speed then 8 px/frame.
      tick(23);
      check("drop_y23", y_s, 396);
      check("drop_hex23", hex_s, 3);
      tick(1);
      check("drop_land_y", y_s, 401);
      check("drop_land_hex", hex_s, 4);
      check("drop_land_air", air_s, 0);
      tick(5);
      check("land_hold_hex", hex_s, 4);
      tick(1);
      check("ground_hex", hex_s, 0);
      check("ground_x", x_s, 320);

      // Walking, key cancel and unknown keys.
      k0_s = 8'h07;
      tick(10);
      check("walk_d_x", x_s, 330);
      k0_s = 8'h04; k1_s = 8'h07;
      tick(3);
      check("a_d_cancel_x", x_s, 330);
      k0_s = 8'h05; k1_s = 8'h00;
      tick(2);
      check("unknown_key_x", x_s, 330);
      k0_s = 8'h00; k1_s = 8'h04;
      tick(305);
      check("walk_a_x25", x_s, 25);
      tick(5);
      check("walk_a_sat", x_s, 24);

      // Full charge, straight jump.
      k1_s = 8'h00; k0_s = 8'h2C;
      tick(20);
      check("charge_sat", chg_s, 12);
      check("charge_hex", hex_s, 1);
      check("charge_x", x_s, 24);
      k0_s = 8'h00;
      tick(1);
      check("release_hex", hex_s, 2);
      check("release_chg", chg_s, 0);
      check("release_air", air_s, 1);
      tick(1);
      check("rise1_y", y_s, 389);
      tick(11);
      check("apex_y", y_s, 323);
      check("apex_hex", hex_s, 3);
      n_ticks = 0;
      while (hex_s != 4'd4 && n_ticks < 40) begin
         tick(1);
         n_ticks++;
      end
      check("fall_ticks", n_ticks, 14);
      check("jump_land_y", y_s, 401);
      check("jump_x", x_s, 24);
      tick(6);
      check("jump_ground_hex", hex_s, 0);

      // Right-wall bounce during a short jump.
      k0_s = 8'h07;
      tick(608);
      check("walk_to_632", x_s, 632);
      k0_s = 8'h2C;
      tick(3);
      check("short_charge", chg_s, 3);
      k0_s = 8'h07;
      tick(1);
      k0_s = 8'h00;
      check("bounce_release_hex", hex_s, 2);
      tick(1);
      check("bounce_x1", x_s, 634);
      check("bounce_y1", y_s, 398);
      tick(1);
      check("bounce_clamp", x_s, 635);
      check("bounce_y2", y_s, 396);
      tick(1);
      check("bounce_back", x_s, 633);
      check("bounce_y3", y_s, 395);
      check("bounce_hex3", hex_s, 3);
      tick(1);
      check("bounce_x4", x_s, 631);
      tick(2);
      check("bounce_land_x", x_s, 627);
      check("bounce_land_y", y_s, 401);
      check("bounce_land_hex", hex_s, 4);
      tick(6);
      check("bounce_ground", hex_s, 0);

      // Ceiling clamp on the shallow instance (floor at 56).
      tick_c(7);
      check("c_land_y", y_c_s, 56);
      check("c_land_hex", hex_c_s, 4);
      tick_c(6);
      k0_c_s = 8'h2C;
      tick_c(20);
      k0_c_s = 8'h00;
      tick_c(6);
      check("c_rise5_y", y_c_s, 6);
      check("c_rise5_hex", hex_c_s, 2);
      tick_c(1);
      check("c_ceiling_y", y_c_s, 4);
      check("c_ceiling_hex", hex_c_s, 3);
      tick_c(1);
      check("c_after_ceiling_y", y_c_s, 5);

      // Asynchronous reset in the middle of a rise.
      k0_s = 8'h2C;
      tick(3);
      k0_s = 8'h00;
      tick(2);
      check("pre_reset_y", y_s, 398);
      check("pre_reset_hex", hex_s, 2);
      @(negedge clk_s);
      #2 rst_n_s = 1'b0;
      #1;
      check("async_x", x_s, 320);
      check("async_y", y_s, 240);
      check("async_hex", hex_s, 3);
      check("async_chg", chg_s, 0);
      tick_s = 1'b1;
      @(negedge clk_s);
      check("reset_tick_y", y_s, 240);
      tick_s = 1'b0;
      rst_n_s = 1'b1;
      tick(1);
      check("post_reset_y", y_s, 241);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
